sdes_round_ctrl: RTL and testbench
==================================

# sdes_round_ctrl

Sequential S-DES block controller that owns the 10-bit key, registers the K1/K2 subkeys from `sdes_keygen`, and steps one 8-bit block at a time through IP, two fk rounds with SW, and IP⁻¹. The two rounds share one fk unit (EP, S0/S1, P4). It sits between the board I/O layer (switches/UART front end) and the S-DES datapath. Blocks enter and leave through valid/ready handshakes, and each transaction selects encrypt or decrypt.

## Interface
- Parameters: none.
- `i_clk` in 1: single clock; all state updates on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_key` in 10: raw S-DES key; sampled only when the key load is accepted.
- `i_key_load` in 1: key load strobe; accepted only in IDLE.
- `o_key_valid` out 1: K1/K2 registers hold subkeys for a loaded key.
- `i_valid` in 1: input block valid.
- `o_ready` out 1: controller accepts a block (IDLE && `o_key_valid`).
- `i_data` in 8: plaintext or ciphertext block.
- `i_decrypt` in 1: 0 = encrypt (K1 then K2), 1 = decrypt (K2 then K1); sampled at accept.
- `o_valid` out 1: result valid; held until consumed.
- `i_ready` in 1: downstream accepts the result.
- `o_data` out 8: result block.
- `o_busy` out 1: state ≠ IDLE.

## Operation
- States:
  - IDLE → R1 on accept (`i_valid && o_ready`).
  - R1 → R2 unconditionally.
  - R2 → DONE unconditionally.
  - DONE → IDLE when `i_ready`.
- Key load:
  - In IDLE, `i_key_load` registers `i_key` and updates the K1/K2 registers from `sdes_keygen`.
  - `o_key_valid` is set and stays set until reset.
  - `i_key_load` outside IDLE is ignored; the key is unchanged.
- Accept:
  - Latch IP(`i_data`), `i_decrypt`, and a snapshot of the subkey pair in round order into the transaction registers.
- R1: state ← SW(fk(state, first subkey)).
- R2: `o_data` ← IP⁻¹(fk(state, second subkey)); `o_valid` set on entry to DONE.
- DONE:
  - `o_data` and `o_valid` stay stable until `i_ready`.
  - `o_valid` clears on the cycle after the handshake.
- Bit order: bit 7/9 is S-DES bit 1. fk, EP, S0, S1, and P4 follow the standard S-DES definitions.
- Boundaries:
  - Accept and `i_key_load` in the same IDLE cycle: both are honoured. The block uses the OLD subkeys (snapshot), and the new key applies to the next block.
  - Accept with `o_key_valid` = 0 is impossible, because `o_ready` is 0.
  - `i_ready` outside DONE is ignored.
  - `i_rst` in any state returns to IDLE, discards the in-flight block, and clears `o_key_valid`.
- Reset values:
  - `o_valid` = 0, `o_data` = 0, `o_key_valid` = 0, `o_ready` = 0, `o_busy` = 0.
  - Key and subkey registers = 0.

## Timing
- Key load accepted at cycle t: `o_key_valid` = 1 and subkeys usable from t+1; earliest block accept is at t+1.
- Block accepted at cycle n: R1 at n+1, R2 at n+2, `o_valid` = 1 from n+3.
- Latency from accept to `o_valid` is 3 cycles.
- With `i_ready` held high, `o_valid` lasts 1 cycle (n+3), IDLE resumes at n+4, and the next accept is at n+4. Sustained throughput is one block per 4 cycles.
- `o_ready` and `o_busy` are decoded from registered state only; neither has a combinational path from any input.

## Configuration
- `SDES_BLOCK_CNT_EN`:
  - When defined, adds output `o_blk_cnt` [15:0]. It increments on each DONE handshake (`o_valid && i_ready`) and wraps 0xFFFF → 0x0000.
  - It resets to 0 on `i_rst`; key loads do not clear it.
- When undefined, the port and counter are absent; all other behaviour is identical.

## Test plan
- Load key 10'b1010000010; encrypt 8'b10010111. Required: K1 = 8'b10100100, K2 = 8'b01000011, and `o_data` = 8'b00111000 exactly 3 cycles after accept.
- Same key; decrypt 8'b00111000. Required: `o_data` = 8'b10010111.
- Backpressure: hold `i_ready` = 0 for 5 cycles in DONE. Required: `o_valid` and `o_data` stay stable and `o_ready` stays 0; on release, IDLE follows the next cycle.
- Key races:
  - Key load while busy: the key is ignored and the subsequent block still uses the old key.
  - Key load plus accept in the same cycle: the current block uses the old key and the next block uses the new key.
- Reset: assert `i_rst` during R2. Required: next cycle all outputs are 0, `o_valid` never rises, and `o_ready` stays 0 until a new key load.
- With `SDES_BLOCK_CNT_EN`: 3 handshakes give `o_blk_cnt` = 3. Forcing the counter to 0xFFFF, then one more handshake, gives 0x0000.

Source files
------------

// File: rtl/sdes_round_ctrl.sv
// S-DES block controller: key/subkey registers, shared fk unit, IP -> fk -> SW -> fk -> IP^-1.
// Optional SDES_BLOCK_CNT_EN adds a 16-bit count of completed output handshakes.

module sdes_keygen (
  input  logic [9:0] i_key,
  output logic [7:0] o_k1,
  output logic [7:0] o_k2
);
  logic [9:0] p10;
  logic [4:0] l1, r1, l2, r2;

  function automatic logic [7:0] p8(input logic [9:0] x);
    return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
  endfunction

  always_comb begin
    p10  = {i_key[7], i_key[5], i_key[8], i_key[3], i_key[6],
            i_key[0], i_key[9], i_key[1], i_key[2], i_key[4]};
    l1   = {p10[8:5], p10[9]};
    r1   = {p10[3:0], p10[4]};
    l2   = {l1[2:0], l1[4:3]};
    r2   = {r1[2:0], r1[4:3]};
    o_k1 = p8({l1, r1});
    o_k2 = p8({l2, r2});
  end
endmodule

module sdes_round_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_key,
  input  logic       i_key_load,
  output logic       o_key_valid,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic       i_decrypt,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_busy
`ifdef SDES_BLOCK_CNT_EN
  ,
  output logic [15:0] o_blk_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_e;

  localparam logic [1:0] S0_T [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                       2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1_T [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                       2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  state_e     state_q;
  logic [9:0] key_q, key_d;
  logic [7:0] k1_q, k2_q, k1_d, k2_d;
  logic [7:0] blk_q, sk1_q, sk2_q, data_q;
  logic       valid_q, key_valid_q;
  logic       key_load_acc, blk_acc;
  logic [7:0] fk_key, fk_out;
`ifdef SDES_BLOCK_CNT_EN
  logic [15:0] blk_cnt_q;
`endif

  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] sk);
    logic [7:0] e;
    logic [1:0] a, b;
    logic [3:0] s;
    e = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ sk;
    a = S0_T[{e[7], e[4], e[6], e[5]}];
    b = S1_T[{e[3], e[0], e[2], e[1]}];
    s = {a, b};
    return {d[7:4] ^ {s[2], s[0], s[1], s[3]}, d[3:0]};
  endfunction

  assign key_load_acc = (state_q == IDLE) && i_key_load;
  assign blk_acc      = (state_q == IDLE) && key_valid_q && i_valid;

  // Keygen sees the incoming key on a load so the new subkeys land in the same edge.
  always_comb key_d = key_load_acc ? i_key : key_q;

  sdes_keygen u_keygen (.i_key(key_d), .o_k1(k1_d), .o_k2(k2_d));

  always_comb begin
    fk_key = (state_q == R2) ? sk2_q : sk1_q;
    fk_out = fk(blk_q, fk_key);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      blk_q       <= '0;
      sk1_q       <= '0;
      sk2_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef SDES_BLOCK_CNT_EN
      blk_cnt_q   <= '0;
`endif
    end else begin
      if (key_load_acc) begin
        key_q       <= i_key;
        k1_q        <= k1_d;
        k2_q        <= k2_d;
        key_valid_q <= 1'b1;
      end
`ifdef SDES_BLOCK_CNT_EN
      if (valid_q && i_ready) blk_cnt_q <= blk_cnt_q + 16'd1;
`endif
      case (state_q)
        IDLE: begin
          // Subkey snapshot uses the pre-load registers, so a same-cycle key load affects only later blocks.
          if (blk_acc) begin
            blk_q   <= ip(i_data);
            sk1_q   <= i_decrypt ? k2_q : k1_q;
            sk2_q   <= i_decrypt ? k1_q : k2_q;
            state_q <= R1;
          end
        end
        R1: begin
          blk_q   <= {fk_out[3:0], fk_out[7:4]};
          state_q <= R2;
        end
        R2: begin
          data_q  <= ip_inv(fk_out);
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_key_valid = key_valid_q;
  assign o_ready     = (state_q == IDLE) && key_valid_q;
  assign o_busy      = (state_q != IDLE);
`ifdef SDES_BLOCK_CNT_EN
  assign o_blk_cnt   = blk_cnt_q;
`endif
endmodule

// File: tb/tb_sdes_round_ctrl.sv
// Self-checking bench for sdes_round_ctrl: vector table, hand-written corner sequences and
// randomized blocks checked against a table-driven S-DES reference model.

module tb_sdes_round_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst, i_key_load, i_valid, i_decrypt, i_ready;
  logic [9:0] i_key;
  logic [7:0] i_data;
  logic       o_key_valid, o_ready, o_valid, o_busy;
  logic [7:0] o_data;
`ifdef SDES_BLOCK_CNT_EN
  logic [15:0] o_blk_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] model_key;

  always #5 i_clk = ~i_clk;

  sdes_round_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key), .i_key_load(i_key_load),
    .o_key_valid(o_key_valid), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_decrypt(i_decrypt), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_busy(o_busy)
`ifdef SDES_BLOCK_CNT_EN
    , .o_blk_cnt(o_blk_cnt)
`endif
  );

  // Reference model: standard S-DES tables, 1-based bit positions counted from the MSB.
  localparam int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  localparam int IP_T[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  localparam int IPI_T[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  localparam int EP_T[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  localparam int P4_T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  localparam int S0_M[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1_M[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic logic [9:0] perm(input logic [9:0] x, input int n_in, input int n_out,
                                      input int p[10]);
    logic [9:0] r = '0;
    for (int j = 0; j < n_out; j++) r[n_out-1-j] = x[n_in-p[j]];
    return r;
  endfunction

  function automatic int rotl5(input int v, input int n);
    return ((v << n) | (v >> (5 - n))) & 31;
  endfunction

  function automatic void model_subkeys(input logic [9:0] key, output logic [7:0] k1,
                                        output logic [7:0] k2);
    int p, l, r;
    logic [9:0] t;
    p = int'(perm(key, 10, 10, P10_T));
    l = p / 32;
    r = p % 32;
    t = 10'(rotl5(l, 1) * 32 + rotl5(r, 1));
    t = perm(t, 10, 8, P8_T);
    k1 = t[7:0];
    t = 10'(rotl5(l, 3) * 32 + rotl5(r, 3));
    t = perm(t, 10, 8, P8_T);
    k2 = t[7:0];
  endfunction

  function automatic logic [7:0] model_fk(input logic [7:0] d, input logic [7:0] sk);
    logic [9:0] t;
    logic [7:0] e;
    int a, b;
    t = perm({6'd0, d[3:0]}, 4, 8, EP_T);
    e = t[7:0] ^ sk;
    a = S0_M[2*e[7]+e[4]][2*e[6]+e[5]];
    b = S1_M[2*e[3]+e[0]][2*e[2]+e[1]];
    t = perm(10'(a * 4 + b), 4, 4, P4_T);
    return {d[7:4] ^ t[3:0], d[3:0]};
  endfunction

  function automatic logic [7:0] model_crypt(input logic [7:0] d, input logic [9:0] key,
                                             input logic dec);
    logic [7:0] k1, k2, x;
    logic [9:0] t;
    model_subkeys(key, k1, k2);
    t = perm({2'd0, d}, 8, 8, IP_T);
    x = model_fk(t[7:0], dec ? k2 : k1);
    x = model_fk({x[3:0], x[7:4]}, dec ? k1 : k2);
    t = perm({2'd0, x}, 8, 8, IPI_T);
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 16) begin tick(); n++; end
    check("ready_wait", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 12) begin tick(); lat++; end
    check("latency", lat, 3);
  endtask

  task automatic load_key(input logic [9:0] k);
    wait_ready_idle();
    i_key = k; i_key_load = 1'b1;
    tick();
    i_key_load = 1'b0;
    model_key = k;
    check("key_valid", {31'd0, o_key_valid}, 32'd1);
  endtask

  task automatic wait_ready_idle();
    int n = 0;
    while (o_busy && n < 16) begin tick(); n++; end
    check("idle_wait", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("post_hs", {30'd0, o_valid, o_busy}, 32'd0);
  endtask

  task automatic accept(input logic [7:0] d, input logic dec);
    wait_ready();
    i_data = d; i_decrypt = dec; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic do_block(input string name, input logic [7:0] d, input logic dec,
                          input logic [7:0] exp, input int stall);
    int lat;
    logic [7:0] cap;
    accept(d, dec);
    wait_valid(lat);
    cap = o_data;
    check(name, {24'd0, o_data}, {24'd0, exp});
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_hold", {22'd0, o_valid, o_ready, o_data}, {22'd0, 1'b1, 1'b0, cap});
    end
    handshake();
  endtask

  typedef struct {
    logic [9:0] key;
    logic [7:0] din;
    logic       dec;
    logic [7:0] dout;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int lat;
    logic [9:0] old_key, new_key;
    logic [7:0] d, cap;
    logic dec;

    i_rst = 1'b1; i_key = '0; i_key_load = 1'b0; i_valid = 1'b0;
    i_data = '0; i_decrypt = 1'b0; i_ready = 1'b0; model_key = '0;

    tbl[0] = '{10'b1010000010, 8'b10010111, 1'b0, 8'b00111000};
    tbl[1] = '{10'b1010000010, 8'b00111000, 1'b1, 8'b10010111};
    tbl[2] = '{10'h3FF, 8'h00, 1'b0, model_crypt(8'h00, 10'h3FF, 1'b0)};
    tbl[3] = '{10'h3FF, model_crypt(8'hA5, 10'h3FF, 1'b0), 1'b1, 8'hA5};
    tbl[4] = '{10'h000, 8'hFF, 1'b0, model_crypt(8'hFF, 10'h000, 1'b0)};
    tbl[5] = '{10'h2C5, 8'h5A, 1'b1, model_crypt(8'h5A, 10'h2C5, 1'b1)};

    tick(); tick();
    check("reset_outs", {o_valid, o_key_valid, o_ready, o_busy, o_data}, 12'd0);
    i_rst = 1'b0;
    tick();
    check("ready_no_key", {31'd0, o_ready}, 32'd0);

    // Known-answer vectors.
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || tbl[i].key != model_key) load_key(tbl[i].key);
      if (i == 0) begin
        check("k1", {24'd0, dut.k1_q}, 32'b10100100);
        check("k2", {24'd0, dut.k2_q}, 32'b01000011);
      end
      do_block("table", tbl[i].din, tbl[i].dec, tbl[i].dout, 0);
    end

    // Backpressure: result held for 5 cycles, IDLE right after release.
    load_key(10'b1010000010);
    do_block("backpressure", 8'b10010111, 1'b0, 8'b00111000, 5);
    check("idle_after_bp", {30'd0, o_ready, o_busy}, 32'b10);

    // i_ready high throughout: o_valid is a single-cycle pulse at n+3.
    i_ready = 1'b1;
    accept(8'h3C, 1'b0);
    check("early_rdy_r1", {31'd0, o_valid}, 32'd0);
    tick();
    check("early_rdy_r2", {31'd0, o_valid}, 32'd0);
    tick();
    check("early_rdy_done", {o_valid, o_data}, {1'b1, model_crypt(8'h3C, model_key, 1'b0)});
    tick();
    check("early_rdy_idle", {o_valid, o_ready}, 2'b01);
    i_ready = 1'b0;

    // Key load while busy is ignored.
    old_key = model_key;
    accept(8'hC3, 1'b1);
    i_key = 10'h155; i_key_load = 1'b1;
    wait_valid(lat);
    check("busy_load_blk", {24'd0, o_data}, {24'd0, model_crypt(8'hC3, old_key, 1'b1)});
    handshake();
    i_key_load = 1'b0;
    do_block("busy_load_next", 8'h71, 1'b0, model_crypt(8'h71, old_key, 1'b0), 0);

    // Key load and accept in the same cycle: old key now, new key next.
    new_key = 10'h2B6;
    wait_ready();
    i_key = new_key; i_key_load = 1'b1;
    i_data = 8'h96; i_decrypt = 1'b0; i_valid = 1'b1;
    tick();
    i_key_load = 1'b0; i_valid = 1'b0;
    wait_valid(lat);
    check("race_old", {24'd0, o_data}, {24'd0, model_crypt(8'h96, old_key, 1'b0)});
    handshake();
    model_key = new_key;
    do_block("race_new", 8'h96, 1'b0, model_crypt(8'h96, new_key, 1'b0), 0);

`ifdef SDES_BLOCK_CNT_EN
    begin
      logic [15:0] c0;
      c0 = o_blk_cnt;
      for (int i = 0; i < 3; i++) do_block("cnt_blk", 8'(i), 1'b0, model_crypt(8'(i), model_key, 1'b0), 0);
      check("blk_cnt_3", {16'd0, o_blk_cnt}, {16'd0, c0 + 16'd3});
      force dut.blk_cnt_q = 16'hFFFF;
      tick();
      release dut.blk_cnt_q;
      do_block("cnt_wrap_blk", 8'h11, 1'b0, model_crypt(8'h11, model_key, 1'b0), 0);
      check("blk_cnt_wrap", {16'd0, o_blk_cnt}, 32'd0);
    end
`endif

    // Randomized blocks with occasional key reloads and backpressure.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) load_key(10'($urandom));
      d = 8'($urandom);
      dec = 1'($urandom);
      do_block("random", d, dec, model_crypt(d, model_key, dec), int'($urandom_range(2)));
    end

    // Reset during R2 discards the block and the key.
    accept(8'h42, 1'b0);
    tick();
    check("in_r2_busy", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_r2_outs", {o_valid, o_key_valid, o_ready, o_busy, o_data}, 12'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_r2_quiet", {30'd0, o_valid, o_ready}, 32'd0);
    end
    load_key(10'b1010000010);
    do_block("post_rst", 8'b10010111, 1'b0, 8'b00111000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end
endmodule
